// File: rtl/cic_decimate.sv
// CIC decimator: N strobe-gated integrators, run-time decimation factor R,
// N decimated-rate combs with differential delay 1, and gain normalisation
// by truncating the last comb output to WIDTH bits starting at bit
// S = N*ceil(log2 R). The pipeline from the strobe that closes a group to
// strobe_out is N+2 clocks.
module cic_decimate #(
   parameter int WIDTH         = 16,
   parameter int N             = 4,
   parameter int MAX_RATE_LOG2 = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rate_stb,
   input  logic [8:0]              rate,
   input  logic                    strobe_in,
   input  logic                    last_in,
   input  logic signed [WIDTH-1:0] signal_in,
   output logic                    strobe_out,
   output logic                    last_out,
   output logic signed [WIDTH-1:0] signal_out
);

   // Internal width: enough headroom for a gain of up to (2^MAX_RATE_LOG2)^N.
   localparam int W  = WIDTH + N * MAX_RATE_LOG2;
   localparam int SW = $clog2(W + 1);

   // Rate control and decimation counter
   logic [8:0]          rate_reg;
   logic [8:0]          eff_rate;
   logic [3:0]          rate_log2;
   logic [SW-1:0]       shift_amt;
   logic [8:0]          dec_cnt;
   logic                group_done;

   // Integrator cascade
   logic signed [W-1:0] sig_ext;
   logic signed [W-1:0] integ     [N];
   logic signed [W-1:0] integ_nxt [N];

   // Decimation event, sampled from the last integrator
   logic                ev_valid;
   logic                ev_last;
   logic [SW-1:0]       ev_shift;
   logic                dec_valid;
   logic                dec_last;
   logic [SW-1:0]       dec_shift;
   logic signed [W-1:0] dec_data;

   // Comb pipeline: each stage carries its event's valid/last/shift along.
   logic                stage_valid [N];
   logic                stage_last  [N];
   logic [SW-1:0]       stage_shift [N];
   logic signed [W-1:0] stage_data  [N];
   logic                c_valid     [N];
   logic                c_last      [N];
   logic [SW-1:0]       c_shift     [N];
   logic signed [W-1:0] c_data      [N];
   logic signed [W-1:0] c_delay     [N];

   // Effective decimation factor, its ceil(log2) and the output shift S
   always_comb begin
      if (rate_reg == 9'd0)
         eff_rate = 9'd1;
      else if (rate_reg > 9'd256)
         eff_rate = 9'd256;
      else
         eff_rate = rate_reg;

      rate_log2 = '0;
      for (int i = 0; i < 9; i++) begin
         if ((9'd1 << i) < eff_rate)
            rate_log2 = 4'(i + 1);
      end

      shift_amt  = SW'(N * int'(rate_log2));
      group_done = ((dec_cnt + 9'd1) == eff_rate) || last_in;
   end

   // Integrator next values: the whole cascade settles within one strobe, so
   // with R=1 the output tracks the input sample-for-sample.
   always_comb begin
      sig_ext      = {{(W-WIDTH){signal_in[WIDTH-1]}}, signal_in};
      integ_nxt[0] = integ[0] + sig_ext;
      for (int i = 1; i < N; i++)
         integ_nxt[i] = integ[i] + integ_nxt[i-1];
   end

   // Rate register, decimation counter, integrators and event generation
   always_ff @(posedge clk) begin
      // NOTE: every register here is state, so it is assigned with <= only;
      // a blocking = would let later statements see the new value this cycle.
      if (!reset) begin
         rate_reg <= 9'd1;
         dec_cnt  <= '0;
         ev_valid <= 1'b0;
         ev_last  <= 1'b0;
         ev_shift <= '0;
         for (int i = 0; i < N; i++)
            integ[i] <= '0;
      end else if (rate_stb) begin
         // New rate: restart the integrator path; strobe_in is ignored.
         rate_reg <= rate;
         dec_cnt  <= '0;
         ev_valid <= 1'b0;
         ev_last  <= 1'b0;
         for (int i = 0; i < N; i++)
            integ[i] <= '0;
      end else begin
         ev_valid <= 1'b0;
         ev_last  <= 1'b0;
         if (strobe_in) begin
            for (int i = 0; i < N; i++)
               integ[i] <= integ_nxt[i];
            if (group_done) begin
               dec_cnt  <= '0;
               ev_valid <= 1'b1;
               ev_last  <= last_in;
               ev_shift <= shift_amt;
            end else begin
               dec_cnt <= dec_cnt + 9'd1;
            end
         end
      end
   end

   // Capture the last integrator one clock after the event; this still reads
   // the pre-clear value if a rate_stb lands in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dec_valid <= 1'b0;
         dec_last  <= 1'b0;
         dec_shift <= '0;
         dec_data  <= '0;
      end else begin
         dec_valid <= ev_valid;
         dec_last  <= ev_last;
         dec_shift <= ev_shift;
         if (ev_valid)
            dec_data <= integ[N-1];
      end
   end

   // Route each comb stage's input from the previous stage
   always_comb begin
      stage_valid[0] = dec_valid;
      stage_last[0]  = dec_last;
      stage_shift[0] = dec_shift;
      stage_data[0]  = dec_data;
      for (int i = 1; i < N; i++) begin
         stage_valid[i] = c_valid[i-1];
         stage_last[i]  = c_last[i-1];
         stage_shift[i] = c_shift[i-1];
         stage_data[i]  = c_data[i-1];
      end
   end

   // Comb cascade: each stage steps only when an event reaches it
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            c_valid[i] <= 1'b0;
            c_last[i]  <= 1'b0;
            c_shift[i] <= '0;
            c_data[i]  <= '0;
            c_delay[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            c_valid[i] <= stage_valid[i];
            c_last[i]  <= stage_valid[i] & stage_last[i];
            c_shift[i] <= stage_shift[i];
            if (stage_valid[i]) begin
               c_data[i]  <= stage_data[i] - c_delay[i];
               c_delay[i] <= stage_data[i];
            end
         end
         // A rate change clears comb history; events in flight keep moving.
         if (rate_stb) begin
            for (int i = 0; i < N; i++)
               c_delay[i] <= '0;
         end
      end
   end

   // Registered outputs: scale by 2^-S, truncate, and pulse strobe_out
   always_ff @(posedge clk) begin
      if (!reset) begin
         strobe_out <= 1'b0;
         last_out   <= 1'b0;
         signal_out <= '0;
      end else begin
         strobe_out <= c_valid[N-1];
         last_out   <= c_valid[N-1] & c_last[N-1];
         if (c_valid[N-1])
            signal_out <= WIDTH'(c_data[N-1] >> c_shift[N-1]);
      end
   end

endmodule

// File: tb/tb_cic_decimate.sv
// Directed bench for cic_decimate (WIDTH=16, N=4, MAX_RATE_LOG2=8).
// Inputs are driven 1 ns after each rising edge; outputs are sampled there
// too. Every output pulse is logged with the edge number that raised it, and
// every accepted input with the edge that sampled it, so latency = 6 edges.
module tb_cic_decimate;

   logic               clk = 1'b0;
   logic               reset;
   logic               rate_stb;
   logic [8:0]         rate;
   logic               strobe_in;
   logic               last_in;
   logic signed [15:0] signal_in;
   logic               strobe_out;
   logic               last_out;
   logic signed [15:0] signal_out;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   int out_val [$];
   bit out_last[$];
   int out_cyc [$];
   int in_edge [$];

   cic_decimate #(.WIDTH(16), .N(4), .MAX_RATE_LOG2(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .rate_stb   (rate_stb),
      .rate       (rate),
      .strobe_in  (strobe_in),
      .last_in    (last_in),
      .signal_in  (signal_in),
      .strobe_out (strobe_out),
      .last_out   (last_out),
      .signal_out (signal_out)
   );

   always #5 clk = ~clk;

   // Advance one clock, then log any output pulse.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (strobe_out) begin
         out_val.push_back(int'(signal_out));
         out_last.push_back(last_out);
         out_cyc.push_back(cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input int v, input bit last);
      strobe_in = 1'b1;
      last_in   = last;
      signal_in = 16'(v);
      in_edge.push_back(cyc + 1);
      step();
      strobe_in = 1'b0;
      last_in   = 1'b0;
   endtask

   task automatic clear_logs();
      out_val.delete();
      out_last.delete();
      out_cyc.delete();
      in_edge.delete();
   endtask

   // Drain anything in flight, then load a new rate.
   task automatic load_rate(input logic [8:0] r);
      idle(10);
      clear_logs();
      rate_stb = 1'b1;
      rate     = r;
      step();
      rate_stb = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle(3);
      n_vec++;
      if (strobe_out !== 1'b0 || last_out !== 1'b0 || signal_out !== 16'sd0) begin
         n_miss++;
         $display("FAIL reset_outputs: got strobe=%b last=%b sig=%0d, want 0 0 0",
                  strobe_out, last_out, signal_out);
      end
      reset = 1'b1;
      clear_logs();
      // Rate register resets to 1: a single sample passes straight through.
      send(5, 1'b0);
      idle(8);
      n_vec++;
      if (out_val.size() != 1 || out_val[0] != 5 || out_cyc[0] - in_edge[0] != 6) begin
         n_miss++;
         $display("FAIL reset_rate1: got %0d outputs (first=%0d), want 1 output of 5 at latency 6",
                  out_val.size(), (out_val.size() > 0) ? out_val[0] : 0);
      end
   endtask

   task automatic test_rate32_dc();
      load_rate(9'd32);
      repeat (192) send(1000, 1'b0);
      idle(10);
      n_vec++;
      if (out_val.size() != 6) begin
         n_miss++;
         $display("FAIL r32_count: got %0d outputs, want 6", out_val.size());
      end else begin
         n_vec++;
         if (out_val[4] != 1000 || out_val[5] != 1000) begin
            n_miss++;
            $display("FAIL r32_value: got %0d,%0d, want 1000,1000", out_val[4], out_val[5]);
         end
         n_vec++;
         if (out_cyc[1] - out_cyc[0] != 32 || out_cyc[5] - in_edge[191] != 6) begin
            n_miss++;
            $display("FAIL r32_timing: got spacing %0d latency %0d, want 32 and 6",
                     out_cyc[1] - out_cyc[0], out_cyc[5] - in_edge[191]);
         end
      end
   endtask

   task automatic test_r256_extremes(input logic [8:0] r, input int dc);
      load_rate(r);
      repeat (1280) send(dc, 1'b0);
      idle(10);
      n_vec++;
      if (out_val.size() != 5) begin
         n_miss++;
         $display("FAIL r256_count rate=%0d: got %0d outputs, want 5", r, out_val.size());
      end else begin
         n_vec++;
         if (out_val[4] != dc) begin
            n_miss++;
            $display("FAIL r256_value rate=%0d: got %0d, want %0d", r, out_val[4], dc);
         end
      end
   endtask

   task automatic test_r3_gain();
      // Non-power-of-2: gain 3^4/2^8 = 81/256, so DC 256 settles at 81.
      load_rate(9'd3);
      repeat (15) send(256, 1'b0);
      idle(10);
      n_vec++;
      if (out_val.size() != 5 || out_val[4] != 81) begin
         n_miss++;
         $display("FAIL r3_gain: got %0d outputs (last=%0d), want 5 outputs ending 81",
                  out_val.size(), (out_val.size() > 0) ? out_val[out_val.size()-1] : 0);
      end
   endtask

   task automatic test_r4_toggle();
      load_rate(9'd4);
      repeat (8) begin
         send(500, 1'b0);
         idle(1);
      end
      idle(10);
      n_vec++;
      if (out_val.size() != 2) begin
         n_miss++;
         $display("FAIL r4_count: got %0d outputs, want 2", out_val.size());
      end else begin
         n_vec++;
         if (out_cyc[0] - in_edge[3] != 6 || out_cyc[1] - in_edge[7] != 6) begin
            n_miss++;
            $display("FAIL r4_latency: got %0d,%0d, want 6,6",
                     out_cyc[0] - in_edge[3], out_cyc[1] - in_edge[7]);
         end
         n_vec++;
         if (strobe_out !== 1'b0 || int'(signal_out) != out_val[1]) begin
            n_miss++;
            $display("FAIL r4_hold: got strobe=%b sig=%0d, want 0 and %0d",
                     strobe_out, signal_out, out_val[1]);
         end
      end
   endtask

   task automatic test_last();
      load_rate(9'd8);
      send(100, 1'b0);
      send(100, 1'b0);
      send(100, 1'b1);
      idle(10);
      n_vec++;
      if (out_val.size() != 1 || out_last[0] !== 1'b1 || out_cyc[0] - in_edge[2] != 6) begin
         n_miss++;
         $display("FAIL last_partial: got %0d outputs (last=%b), want 1 flagged output at latency 6",
                  out_val.size(), (out_last.size() > 0) ? out_last[0] : 1'b0);
      end
      clear_logs();
      repeat (7) send(200, 1'b0);
      idle(10);
      n_vec++;
      if (out_val.size() != 0) begin
         n_miss++;
         $display("FAIL last_fresh7: got %0d outputs after 7 inputs, want 0", out_val.size());
      end
      send(200, 1'b0);
      idle(10);
      n_vec++;
      if (out_val.size() != 1 || out_last[0] !== 1'b0 || out_cyc[0] - in_edge[7] != 6) begin
         n_miss++;
         $display("FAIL last_fresh8: got %0d outputs, want 1 unflagged output at latency 6",
                  out_val.size());
      end
   endtask

   task automatic test_r1_ramp(input logic [8:0] r, input int base);
      load_rate(r);
      for (int i = 0; i < 20; i++) send(base + i, 1'b0);
      idle(10);
      n_vec++;
      if (out_val.size() != 20) begin
         n_miss++;
         $display("FAIL r1_count rate=%0d: got %0d outputs, want 20", r, out_val.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            n_vec++;
            if (out_val[i] != base + i || out_cyc[i] - in_edge[i] != 6) begin
               n_miss++;
               $display("FAIL r1_ramp rate=%0d idx=%0d: got %0d at latency %0d, want %0d at 6",
                        r, i, out_val[i], out_cyc[i] - in_edge[i], base + i);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      load_rate(9'd8);
      repeat (8) send(1000, 1'b0);
      idle(2);
      // Reset with a group in the comb pipeline; rate_stb must be ignored.
      reset    = 1'b0;
      rate_stb = 1'b1;
      rate     = 9'd5;
      step();
      n_vec++;
      if (strobe_out !== 1'b0 || last_out !== 1'b0 || signal_out !== 16'sd0) begin
         n_miss++;
         $display("FAIL midreset_outputs: got strobe=%b last=%b sig=%0d, want 0 0 0",
                  strobe_out, last_out, signal_out);
      end
      step();
      reset    = 1'b1;
      rate_stb = 1'b0;
      idle(10);
      n_vec++;
      if (out_val.size() != 0) begin
         n_miss++;
         $display("FAIL midreset_stale: got %0d outputs after reset, want 0", out_val.size());
      end
      clear_logs();
      send(-3, 1'b0);
      send(7, 1'b0);
      send(1234, 1'b0);
      idle(10);
      n_vec++;
      if (out_val.size() != 3 || out_val[0] != -3 || out_val[1] != 7 || out_val[2] != 1234
          || out_cyc[2] - in_edge[2] != 6) begin
         n_miss++;
         $display("FAIL midreset_resume: got %0d outputs, want -3,7,1234 at latency 6",
                  out_val.size());
      end
   endtask

   initial begin
      reset     = 1'b0;
      rate_stb  = 1'b0;
      rate      = '0;
      strobe_in = 1'b0;
      last_in   = 1'b0;
      signal_in = '0;
      test_reset();
      test_rate32_dc();
      test_r256_extremes(9'd256, -32768);
      test_r256_extremes(9'd511, 32767);
      test_r3_gain();
      test_r4_toggle();
      test_last();
      test_r1_ramp(9'd1, 0);
      test_r1_ramp(9'd0, 0);
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/cic_decimate.md
CIC_DECIMATE -- requirements
Module: cic_decimate

Interface
REQ-001 Parameters: WIDTH, default 16, input/output sample width; N, default 4, number of integrator and comb stages; MAX_RATE_LOG2, default 8, log2 of the maximum rate.
REQ-002 Ports: clk, input, 1 bit, sole clock; all logic SHALL be on its rising edge.
REQ-003 Ports: reset, input, 1 bit, synchronous active-low reset (0 = reset).
REQ-004 Ports: rate_stb, input, 1 bit, load strobe for rate.
REQ-005 Ports: rate, input, 9 bits, decimation factor R (unsigned).
REQ-006 Ports: strobe_in, input, 1 bit, marks signal_in and last_in valid this cycle.
REQ-007 Ports: last_in, input, 1 bit, marks the final input sample of a burst.
REQ-008 Ports: signal_in, input, WIDTH bits, signed two's-complement input.
REQ-009 Ports: strobe_out, output, 1 bit, single-cycle output-valid pulse.
REQ-010 Ports: last_out, output, 1 bit, marks the final output of a burst.
REQ-011 Ports: signal_out, output, WIDTH bits, signed two's-complement output.

Function
REQ-012 Internal width SHALL be W = WIDTH + N*MAX_RATE_LOG2 (48 by default); integrators and combs SHALL use wrap-around two's-complement arithmetic at W bits, and signal_in SHALL be sign-extended to W.
REQ-013 With rate_stb=1, the block SHALL latch rate into an internal rate register and clear the decimation counter, all integrators and all combs in the same cycle; strobe_in SHALL be ignored that cycle.
REQ-014 Effective R SHALL be 1 when the latched rate is 0, 256 when it exceeds 256, and otherwise equal to the latched rate.
REQ-015 On each strobe_in=1, all N cascaded integrators SHALL update once and the decimation counter SHALL advance; cycles with strobe_in=0 SHALL change nothing in the integrator path.
REQ-016 The R-th accepted strobe_in of a group SHALL generate one decimation event; the counter SHALL then restart at the next strobe_in.
REQ-017 An accepted strobe_in with last_in=1 SHALL end the current group immediately and generate a decimation event flagged last, even if the group is partial; the counter SHALL restart.
REQ-018 Each decimation event SHALL pass the last integrator value through N cascaded combs with differential delay 1; the combs SHALL run at the decimated rate only.
REQ-019 Gain normalisation: S = N*ceil(log2 R); signal_out SHALL equal bits [S+WIDTH-1:S] of the last comb output (truncation, no rounding).
REQ-020 For power-of-2 R, DC gain SHALL be exactly 1; for other R, gain SHALL be R^N/2^S, which is at most 1.
REQ-021 strobe_out SHALL pulse high for exactly one cycle, N+2 clocks after the cycle of the strobe_in that completed the group.
REQ-022 signal_out SHALL update only in the strobe_out cycle and SHALL hold its value otherwise.
REQ-023 last_out SHALL be high only in the strobe_out cycle of a last-flagged event; otherwise it SHALL be 0.
REQ-024 With R=1, every accepted strobe_in SHALL produce a strobe_out and signal_out SHALL equal signal_in, delayed by N+2 clocks.
REQ-025 Events already in the comb pipeline SHALL still emit when a rate_stb arrives; integrator and counter state SHALL restart from zero.

Reset
REQ-026 When reset=0 at a clock edge: strobe_out=0, last_out=0, signal_out=0, decimation counter=0, all integrators and combs=0, and rate register=1.
REQ-027 rate_stb SHALL have no effect while reset=0; reset SHALL take priority over every other input, mid-operation included, and no pending strobe_out SHALL emit after reset.

Verification
REQ-028 Bench: rate_stb with rate=32, then continuous strobe_in with signal_in=1000 -> after 5 outputs, each strobe_out carries signal_out=1000, with one pulse per 32 inputs.
REQ-029 Bench: R=256, DC input -32768 and separately 32767 -> settled outputs equal -32768 and 32767 exactly, with no wrap.
REQ-030 Bench: R=4, strobe_in toggling every other cycle -> one strobe_out per 4 strobe_in pulses, and latency from the 4th strobe_in is exactly N+2=6 clocks.
REQ-031 Bench: R=8, last_in=1 on the 3rd strobe_in of a group -> one strobe_out with last_out=1 six clocks later, and the next group counts 8 fresh inputs.
REQ-032 Bench: R=1, signal_in ramp 0,1,2,... -> signal_out reproduces the ramp 6 clocks later; also rate=0 -> identical behaviour.
REQ-033 Bench: reset=0 asserted mid-stream -> outputs are 0 next cycle, no stale strobe_out, and output resumes at R=1 after release.
